// File: rtl/object_move_pkg.sv
// Shared types and helpers for the accelerating sprite mover.
package object_move_pkg;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      SPEED_ST = 2'd1,
      POS_ST   = 2'd2,
      LIMIT_ST = 2'd3
   } state_t;

   localparam int EDGE_LEFT   = 3;
   localparam int EDGE_TOP    = 2;
   localparam int EDGE_RIGHT  = 1;
   localparam int EDGE_BOTTOM = 0;

   function automatic logic signed [31:0] sat_add(
      input logic signed [31:0] a,
      input logic signed [31:0] b,
      input logic signed [31:0] lo,
      input logic signed [31:0] hi
   );
      logic signed [31:0] sum;
      sum = a + b;
      if (sum > hi)
         sat_add = hi;
      else if (sum < lo)
         sat_add = lo;
      else
         sat_add = sum;
   endfunction

endpackage

// File: rtl/object_move_accel_axis_speed_step.sv
// One-axis speed update: accelerate toward the held direction, otherwise
// bleed speed toward zero without crossing it.
module axis_speed_step
   import object_move_pkg::*;
#(
   parameter int ACCEL     = 8,
   parameter int DECEL     = 4,
   parameter int MAX_SPEED = 256
) (
   input  logic signed [1:0]  dir,
   input  logic signed [31:0] speed,
   output logic signed [31:0] speed_nxt
);

   always_comb begin
      speed_nxt = speed;
      if (dir == 2'sd1)
         speed_nxt = sat_add(speed, ACCEL, -MAX_SPEED, MAX_SPEED);
      else if (dir == -2'sd1)
         speed_nxt = sat_add(speed, -ACCEL, -MAX_SPEED, MAX_SPEED);
      else if (speed > DECEL)
         speed_nxt = speed - DECEL;
      else if (speed < -DECEL)
         speed_nxt = speed + DECEL;
      else
         speed_nxt = '0;
   end

endmodule

// File: rtl/object_move_accel.sv
// Per-frame sprite position update with acceleration, optional gravity/jump,
// edge-hit blocking and screen-margin clamping.
//
// state    | meaning
// IDLE     | wait for startOfFrame, accumulate collision edge hits
// SPEED_ST | step both speeds, cancel motion into latched hit edges
// POS_ST   | integrate speed into fixed-point position
// LIMIT_ST | clamp to screen, publish topLeft, update onGround
module object_move_accel
   import object_move_pkg::*;
#(
   parameter int INITIAL_X     = 280,
   parameter int INITIAL_Y     = 185,
   parameter int OBJECT_WIDTH  = 64,
   parameter int OBJECT_HEIGHT = 64,
   parameter int SCREEN_W      = 640,
   parameter int SCREEN_H      = 480,
   parameter int MARGIN        = 2,
   parameter int FP_SHIFT      = 6,
   parameter int ACCEL         = 8,
   parameter int DECEL         = 4,
   parameter int MAX_SPEED     = 256,
   parameter int GRAVITY_MODE  = 0,
   parameter int GRAVITY       = 5,
   parameter int JUMP_SPEED    = 320
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               startOfFrame,
   input  logic               up_key_pressed,
   input  logic               down_key_pressed,
   input  logic               right_key_pressed,
   input  logic               left_key_pressed,
   input  logic               collision,
   input  logic [3:0]         HitEdgeCode,
   output logic signed [10:0] topLeftX,
   output logic signed [10:0] topLeftY,
   output logic               onGround
);

   localparam logic signed [31:0] X_LO   = 32'(MARGIN << FP_SHIFT);
   localparam logic signed [31:0] X_HI   = 32'((SCREEN_W - 1 - MARGIN - OBJECT_WIDTH) << FP_SHIFT);
   localparam logic signed [31:0] Y_LO   = 32'(MARGIN << FP_SHIFT);
   localparam logic signed [31:0] Y_HI   = 32'((SCREEN_H - 1 - MARGIN - OBJECT_HEIGHT) << FP_SHIFT);
   localparam logic signed [31:0] X_INIT = 32'(INITIAL_X << FP_SHIFT);
   localparam logic signed [31:0] Y_INIT = 32'(INITIAL_Y << FP_SHIFT);

   state_t             state, state_nxt;
   logic signed [31:0] x_pos, y_pos, x_speed, y_speed;
   logic signed [31:0] x_step, y_step, x_spd_hit, y_spd_hit;
   logic signed [31:0] x_clamp, y_clamp, x_spd_lim, y_spd_lim;
   logic signed [1:0]  dir_x, dir_y;
   logic [3:0]         hit_latch;
   logic               on_ground, y_at_bottom;

   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         state <= IDLE;
      else
         state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:     if (startOfFrame) state_nxt = SPEED_ST;
         SPEED_ST: state_nxt = POS_ST;
         POS_ST:   state_nxt = LIMIT_ST;
         LIMIT_ST: state_nxt = IDLE;
         default:  state_nxt = IDLE;
      endcase
   end

   assign dir_x = (right_key_pressed && !left_key_pressed) ?  2'sd1 :
                  (left_key_pressed && !right_key_pressed) ? -2'sd1 : 2'sd0;
   assign dir_y = (down_key_pressed && !up_key_pressed)    ?  2'sd1 :
                  (up_key_pressed && !down_key_pressed)    ? -2'sd1 : 2'sd0;

   axis_speed_step #(.ACCEL(ACCEL), .DECEL(DECEL), .MAX_SPEED(MAX_SPEED)) u_x_step (
      .dir       (dir_x),
      .speed     (x_speed),
      .speed_nxt (x_step)
   );

   generate
      if (GRAVITY_MODE == 0) begin : g_free_y
         axis_speed_step #(.ACCEL(ACCEL), .DECEL(DECEL), .MAX_SPEED(MAX_SPEED)) u_y_step (
            .dir       (dir_y),
            .speed     (y_speed),
            .speed_nxt (y_step)
         );
      end else begin : g_grav_y
         // Jump speed sits below -MAX_SPEED, so only the downward side saturates.
         always_comb begin
            if (up_key_pressed && on_ground)
               y_step = -JUMP_SPEED;
            else
               y_step = sat_add(y_speed, GRAVITY, -JUMP_SPEED, MAX_SPEED);
         end
      end
   endgenerate

   always_comb begin
      x_spd_hit = x_step;
      y_spd_hit = y_step;
      if ((hit_latch[EDGE_LEFT] && x_step < 0) || (hit_latch[EDGE_RIGHT] && x_step > 0))
         x_spd_hit = '0;
      if ((hit_latch[EDGE_TOP] && y_step < 0) || (hit_latch[EDGE_BOTTOM] && y_step > 0))
         y_spd_hit = '0;
   end

   always_comb begin
      x_clamp     = x_pos;
      y_clamp     = y_pos;
      x_spd_lim   = x_speed;
      y_spd_lim   = y_speed;
      y_at_bottom = 1'b0;
      if (x_pos < X_LO) begin
         x_clamp = X_LO;
         if (x_speed < 0) x_spd_lim = '0;
      end else if (x_pos > X_HI) begin
         x_clamp = X_HI;
         if (x_speed > 0) x_spd_lim = '0;
      end
      if (y_pos < Y_LO) begin
         y_clamp = Y_LO;
         if (y_speed < 0) y_spd_lim = '0;
      end else if (y_pos > Y_HI) begin
         y_clamp     = Y_HI;
         y_at_bottom = 1'b1;
         if (y_speed > 0) y_spd_lim = '0;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         x_pos     <= X_INIT;
         y_pos     <= Y_INIT;
         x_speed   <= '0;
         y_speed   <= '0;
         hit_latch <= '0;
         on_ground <= 1'b0;
         topLeftX  <= 11'(INITIAL_X);
         topLeftY  <= 11'(INITIAL_Y);
      end else begin
         case (state)
            IDLE: if (collision) hit_latch <= hit_latch | HitEdgeCode;
            SPEED_ST: begin
               x_speed <= x_spd_hit;
               y_speed <= y_spd_hit;
            end
            POS_ST: begin
               x_pos <= x_pos + x_speed;
               y_pos <= y_pos + y_speed;
            end
            LIMIT_ST: begin
               x_pos     <= x_clamp;
               y_pos     <= y_clamp;
               x_speed   <= x_spd_lim;
               y_speed   <= y_spd_lim;
               topLeftX  <= 11'(x_clamp >>> FP_SHIFT);
               topLeftY  <= 11'(y_clamp >>> FP_SHIFT);
               on_ground <= (GRAVITY_MODE != 0) && (y_at_bottom || hit_latch[EDGE_BOTTOM]);
               hit_latch <= '0;
            end
            default: ;
         endcase
      end
   end

   assign onGround = on_ground;

endmodule
